// File: rtl/mips_div_pkg.sv
// Shared types and constants for the MIPS DIV/DIVU restoring divider.
package mips_div_pkg;

  localparam int ITERS = 32;
  localparam logic [31:0] DBZ_QUOTIENT = 32'hFFFF_FFFF;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PREP = 3'd1,
    CALC = 3'd2,
    FIX  = 3'd3,
    DONE = 3'd4
  } div_state_e;

  // Magnitude of a two's complement operand; 0x80000000 stays 0x80000000 as unsigned.
  function automatic logic [31:0] abs32(input logic [31:0] val, input logic is_signed);
    logic [31:0] res;
    if (is_signed && val[31]) begin
      res = 32'd0 - val;
    end else begin
      res = val;
    end
    return res;
  endfunction

endpackage

// File: rtl/mips_div_unit_div_step.sv
// One restoring-division iteration: shift in the next dividend bit and trial-subtract.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   rem_i,
  input  logic             quo_msb_i,
  input  logic [WIDTH-1:0] dvs_i,
  output logic [WIDTH:0]   rem_o,
  output logic             q_bit_o
);

  logic [WIDTH+1:0] shifted_s;
  logic [WIDTH+1:0] trial_s;

  // Trial subtraction; a clear sign bit means the divisor fits.
  always_comb begin
    shifted_s = {rem_i, quo_msb_i};
    trial_s   = shifted_s - {2'b00, dvs_i};
    if (!trial_s[WIDTH+1]) begin
      rem_o   = trial_s[WIDTH:0];
      q_bit_o = 1'b1;
    end else begin
      rem_o   = shifted_s[WIDTH:0];
      q_bit_o = 1'b0;
    end
  end

endmodule

// File: rtl/mips_div_unit.sv
// Multi-cycle radix-2 restoring divider producing LO (quotient) and HI (remainder).
module mips_div_unit
  import mips_div_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic             signed_div,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             cancel,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CNT_W = $clog2(ITERS);

  div_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] dividend_q, dividend_d;
  logic [WIDTH-1:0] divisor_q, divisor_d;
  logic             sdiv_q, sdiv_d;
  logic [WIDTH-1:0] dvs_mag_q, dvs_mag_d;
  logic [WIDTH:0]   rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic             dvd_neg_q, dvd_neg_d;
  logic             q_neg_q, q_neg_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             dbz_q, dbz_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH:0]   step_rem_s;
  logic             step_qbit_s;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_i     (rem_q),
    .quo_msb_i (quo_q[WIDTH-1]),
    .dvs_i     (dvs_mag_q),
    .rem_o     (step_rem_s),
    .q_bit_o   (step_qbit_s)
  );

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; cancel always wins over start and over progress.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start && !cancel) state_d = PREP;
        else                  state_d = IDLE;
      end
      PREP: begin
        if (cancel)                 state_d = IDLE;
        else if (divisor_q == '0)   state_d = DONE;
        else                        state_d = CALC;
      end
      CALC: begin
        if (cancel)                               state_d = IDLE;
        else if (cnt_q == CNT_W'(ITERS - 1))      state_d = FIX;
        else                                      state_d = CALC;
      end
      FIX: begin
        if (cancel) state_d = IDLE;
        else        state_d = DONE;
      end
      DONE: begin
        if (start && !cancel) state_d = PREP;
        else                  state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath next values: operand capture, magnitude prep and per-cycle iteration.
  always_comb begin
    dividend_d = dividend_q;
    divisor_d  = divisor_q;
    sdiv_d     = sdiv_q;
    dvs_mag_d  = dvs_mag_q;
    rem_d      = rem_q;
    quo_d      = quo_q;
    cnt_d      = cnt_q;
    dvd_neg_d  = dvd_neg_q;
    q_neg_d    = q_neg_q;
    case (state_q)
      IDLE, DONE: begin
        if (start && !cancel) begin
          dividend_d = dividend;
          divisor_d  = divisor;
          sdiv_d     = signed_div;
        end else begin
          dividend_d = dividend_q;
        end
      end
      PREP: begin
        quo_d     = abs32(dividend_q, sdiv_q);
        dvs_mag_d = abs32(divisor_q, sdiv_q);
        rem_d     = '0;
        cnt_d     = '0;
        dvd_neg_d = sdiv_q & dividend_q[WIDTH-1];
        q_neg_d   = sdiv_q & (dividend_q[WIDTH-1] ^ divisor_q[WIDTH-1]);
      end
      CALC: begin
        rem_d = step_rem_s;
        quo_d = {quo_q[WIDTH-2:0], step_qbit_s};
        cnt_d = cnt_q + CNT_W'(1);
      end
      default: begin
        rem_d = rem_q;
      end
    endcase
  end

  // Output next values; results only change when an operation reaches DONE.
  always_comb begin
    busy_d      = (state_d == PREP) || (state_d == CALC) || (state_d == FIX);
    done_d      = (state_d == DONE);
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;
    if (state_q == PREP && state_d == DONE) begin
      quotient_d  = DBZ_QUOTIENT;
      remainder_d = dividend_q;
      dbz_d       = 1'b1;
    end else if (state_q == FIX && state_d == DONE) begin
      quotient_d  = q_neg_q ? ('0 - quo_q) : quo_q;
      remainder_d = dvd_neg_q ? ('0 - rem_q[WIDTH-1:0]) : rem_q[WIDTH-1:0];
      dbz_d       = 1'b0;
    end else begin
      dbz_d = dbz_q;
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_q       <= '0;
      dividend_q  <= '0;
      divisor_q   <= '0;
      sdiv_q      <= 1'b0;
      dvs_mag_q   <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      dvd_neg_q   <= 1'b0;
      q_neg_q     <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      dividend_q  <= dividend_d;
      divisor_q   <= divisor_d;
      sdiv_q      <= sdiv_d;
      dvs_mag_q   <= dvs_mag_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      dvd_neg_q   <= dvd_neg_d;
      q_neg_q     <= q_neg_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_mips_div_unit.sv
// Self-checking bench for mips_div_unit against an arithmetic reference model.
module tb_mips_div_unit;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        start = 1'b0;
  logic        signed_div = 1'b0;
  logic [31:0] dividend = 32'd0;
  logic [31:0] divisor = 32'd0;
  logic        cancel = 1'b0;
  logic        busy;
  logic        done;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        div_by_zero;

  int n_cmp = 0;
  int n_err = 0;

  mips_div_unit dut (
    .clk         (clk),
    .resetn      (resetn),
    .start       (start),
    .signed_div  (signed_div),
    .dividend    (dividend),
    .divisor     (divisor),
    .cancel      (cancel),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Reference: MIPS semantics via 64-bit signed arithmetic (truncating division).
  function automatic void model(input bit sg, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] q, output logic [31:0] r, output bit z);
    longint x, y, qq, rr;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = a;
      z = 1'b1;
    end else begin
      x  = sg ? longint'($signed(a)) : longint'({32'd0, a});
      y  = sg ? longint'($signed(b)) : longint'({32'd0, b});
      qq = x / y;
      rr = x % y;
      q  = qq[31:0];
      r  = rr[31:0];
      z  = 1'b0;
    end
  endfunction

  task automatic run_div(input bit sg, input logic [31:0] a, input logic [31:0] b, input string tag);
    logic [31:0] eq, er;
    bit ez, seen;
    int cyc, bcnt;
    model(sg, a, b, eq, er, ez);
    @(negedge clk);
    start = 1'b1; signed_div = sg; dividend = a; divisor = b;
    @(posedge clk);
    #1;
    start = 1'b0; dividend = $urandom; divisor = $urandom; signed_div = 1'($urandom_range(0, 1));
    cyc = 0; bcnt = 0; seen = 1'b0;
    while (!seen && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (busy) bcnt++;
      if (done) seen = 1'b1;
    end
    check_eq({tag, " latency"}, cyc, (b == 32'd0) ? 32'd2 : 32'd35);
    check_eq({tag, " busy_cycles"}, bcnt, (b == 32'd0) ? 32'd1 : 32'd34);
    check_eq({tag, " quotient"}, quotient, eq);
    check_eq({tag, " remainder"}, remainder, er);
    check_eq({tag, " dbz"}, {31'd0, div_by_zero}, {31'd0, ez});
    @(negedge clk);
    check_eq({tag, " done_pulse"}, {31'd0, done}, 32'd0);
  endtask

  initial begin
    bit seen_done;
    logic [31:0] ra, rb;
    bit rs;
    repeat (3) @(negedge clk);
    check_eq("rst busy", {31'd0, busy}, 32'd0);
    check_eq("rst done", {31'd0, done}, 32'd0);
    check_eq("rst quotient", quotient, 32'd0);
    check_eq("rst remainder", remainder, 32'd0);
    check_eq("rst dbz", {31'd0, div_by_zero}, 32'd0);
    resetn = 1'b1;

    run_div(1'b0, 32'd100, 32'd7, "divu_100_7");
    run_div(1'b1, 32'hFFFF_FFF9, 32'd2, "div_m7_2");
    run_div(1'b1, 32'd7, 32'hFFFF_FFFE, "div_7_m2");
    run_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
    run_div(1'b0, 32'hFFFF_FFFF, 32'd1, "divu_max_1");
    run_div(1'b0, 32'h1234_5678, 32'd0, "divu_dbz");
    run_div(1'b0, 32'd9, 32'd3, "divu_9_3");
    run_div(1'b1, 32'h8000_0000, 32'd0, "div_dbz");
    run_div(1'b1, 32'h8000_0000, 32'd1, "div_min_1");

    // Ignored restart and cancel mid-CALC.
    run_div(1'b0, 32'd100, 32'd7, "pre_cancel");
    @(negedge clk);
    start = 1'b1; signed_div = 1'b0; dividend = 32'd50; divisor = 32'd5;
    @(posedge clk);
    #1;
    start = 1'b0;
    seen_done = 1'b0;
    for (int c = 1; c <= 14; c++) begin
      @(negedge clk);
      check_eq($sformatf("cancel busy c%0d", c), {31'd0, busy}, (c <= 10) ? 32'd1 : 32'd0);
      if (done) seen_done = 1'b1;
      start  = (c == 5);
      dividend = 32'd99; divisor = 32'd9;
      cancel = (c == 10);
    end
    start = 1'b0; cancel = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done || busy) seen_done = 1'b1;
    end
    check_eq("cancel no_done", {31'd0, seen_done}, 32'd0);
    check_eq("cancel quotient", quotient, 32'd14);
    check_eq("cancel remainder", remainder, 32'd2);
    check_eq("cancel dbz", {31'd0, div_by_zero}, 32'd0);

    // Asynchronous reset in the middle of CALC.
    run_div(1'b0, 32'hDEAD_BEEF, 32'd0, "pre_reset_dbz");
    @(negedge clk);
    start = 1'b1; signed_div = 1'b0; dividend = 32'd100; divisor = 32'd7;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (10) @(negedge clk);
    #2;
    resetn = 1'b0;
    #1;
    check_eq("areset busy", {31'd0, busy}, 32'd0);
    check_eq("areset done", {31'd0, done}, 32'd0);
    check_eq("areset quotient", quotient, 32'd0);
    check_eq("areset remainder", remainder, 32'd0);
    check_eq("areset dbz", {31'd0, div_by_zero}, 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    seen_done = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done) seen_done = 1'b1;
    end
    check_eq("areset no_done", {31'd0, seen_done}, 32'd0);
    run_div(1'b0, 32'd100, 32'd7, "post_reset");

    // Randomized operands with biased corner values.
    for (int i = 0; i < 40; i++) begin
      rs = 1'($urandom_range(0, 1));
      ra = $urandom;
      case ($urandom_range(0, 5))
        0: rb = 32'd0;
        1: rb = 32'hFFFF_FFFF;
        2: rb = 32'($urandom_range(1, 20));
        3: rb = {28'd0, 4'($urandom)} | 32'h8000_0000;
        default: rb = $urandom;
      endcase
      if ($urandom_range(0, 7) == 0) ra = 32'h8000_0000;
      run_div(rs, ra, rb, $sformatf("rnd%0d", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
